// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants for the instruction-fetch front end.
package fetch_pc_unit_pkg;

    localparam logic RST_ENABLE   = 1'b1;
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic STALL        = 1'b1;
    localparam logic FLUSH        = 1'b1;

    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_BUS      = 32;

    localparam logic [INST_BUS-1:0] ZERO_WORD = '0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: flush clears, ID stall holds, IF-only stall injects a bubble.
module if_id_reg
    import fetch_pc_unit_pkg::*;
#(
    parameter int unsigned ADDR_W = INST_ADDR_BUS,
    parameter int unsigned INST_W = INST_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              stall_if_i,
    input  logic              stall_id_i,
    input  logic [ADDR_W-1:0] if_pc_i,
    input  logic [INST_W-1:0] if_inst_i,
    input  logic              if_valid_i,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              valid_q, valid_d;

    always_comb begin
        pc_d    = pc_q;
        inst_d  = inst_q;
        valid_d = valid_q;
        if (rst == RST_ENABLE || flush_i == FLUSH) begin
            pc_d    = '0;
            inst_d  = '0;
            valid_d = 1'b0;
        end else if (stall_id_i == STALL) begin
            // hold
        end else if (stall_if_i == STALL) begin
            pc_d    = '0;
            inst_d  = '0;
            valid_d = 1'b0;
        end else begin
            pc_d    = if_pc_i;
            inst_d  = if_inst_i;
            valid_d = if_valid_i;
        end
    end

    always_ff @(posedge clk) begin
        pc_q    <= pc_d;
        inst_q  <= inst_d;
        valid_q <= valid_d;
    end

    assign id_pc_o    = pc_q;
    assign id_inst_o  = inst_q;
    assign id_valid_o = valid_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch front end: program counter, redirect/pending logic and ROM interface.
module fetch_pc_unit
    import fetch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned ADDR_W   = INST_ADDR_BUS,
    parameter int unsigned INST_W   = INST_BUS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_if_i,
    input  logic              stall_id_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] flush_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [INST_W-1:0] rom_data_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o,
    output logic              id_valid_o
);

    localparam logic [ADDR_W-1:0] AlignMask = ~ADDR_W'(3);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              ce_q, ce_d;
    logic              pend_valid_q, pend_valid_d;
    logic [ADDR_W-1:0] pend_target_q, pend_target_d;

    always_comb begin
        pc_d          = pc_q;
        ce_d          = CHIP_ENABLE;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (rst == RST_ENABLE) begin
            pc_d          = ADDR_W'(RESET_PC);
            ce_d          = CHIP_DISABLE;
            pend_valid_d  = 1'b0;
            pend_target_d = '0;
        end else if (ce_q == CHIP_DISABLE) begin
            // first enabled cycle fetches RESET_PC itself
        end else if (flush_i == FLUSH) begin
            pc_d         = flush_pc_i & AlignMask;
            pend_valid_d = 1'b0;
        end else if (stall_if_i == STALL) begin
            // a branch resolved while IF is frozen must not be lost
            if (branch_flag_i) begin
                pend_valid_d  = 1'b1;
                pend_target_d = branch_target_i & AlignMask;
            end
        end else if (pend_valid_q) begin
            pc_d         = pend_target_q;
            pend_valid_d = 1'b0;
        end else if (branch_flag_i) begin
            pc_d = branch_target_i & AlignMask;
        end else begin
            pc_d = pc_q + ADDR_W'(4);
        end
    end

    always_ff @(posedge clk) begin
        pc_q          <= pc_d;
        ce_q          <= ce_d;
        pend_valid_q  <= pend_valid_d;
        pend_target_q <= pend_target_d;
    end

    assign rom_addr_o = pc_q;
    assign rom_ce_o   = ce_q;

    if_id_reg #(
        .ADDR_W(ADDR_W),
        .INST_W(INST_W)
    ) u_if_id_reg (
        .clk       (clk),
        .rst       (rst),
        .flush_i   (flush_i),
        .stall_if_i(stall_if_i),
        .stall_id_i(stall_id_i),
        .if_pc_i   (pc_q),
        .if_inst_i (rom_data_i),
        .if_valid_i(ce_q),
        .id_pc_o   (id_pc_o),
        .id_inst_o (id_inst_o),
        .id_valid_o(id_valid_o)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed scenarios plus random traffic vs a reference model.
module tb_fetch_pc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_if_i, stall_id_i, flush_i, branch_flag_i;
    logic [31:0] flush_pc_i, branch_target_i, rom_data_i;
    logic [31:0] rom_addr_o, id_pc_o, id_inst_o;
    logic        rom_ce_o, id_valid_o;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc, m_pend, m_id_pc, m_id_inst;
    logic        m_ce, m_pend_v, m_id_valid;

    always #5 clk = ~clk;

    fetch_pc_unit #(
        .RESET_PC(32'h0000_0000),
        .ADDR_W  (32),
        .INST_W  (32)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stall_if_i     (stall_if_i),
        .stall_id_i     (stall_id_i),
        .flush_i        (flush_i),
        .flush_pc_i     (flush_pc_i),
        .branch_flag_i  (branch_flag_i),
        .branch_target_i(branch_target_i),
        .rom_data_i     (rom_data_i),
        .rom_addr_o     (rom_addr_o),
        .rom_ce_o       (rom_ce_o),
        .id_pc_o        (id_pc_o),
        .id_inst_o      (id_inst_o),
        .id_valid_o     (id_valid_o)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h00:  return 32'h3c02_0404;
            32'h04:  return 32'h3442_0404;
            32'h08:  return 32'h3407_0007;
            32'h10:  return 32'h3408_0008;
            32'h30:  return 32'h0002_14c0;
            default: return {a[15:0], ~a[15:0]} ^ 32'h1357_9bdf;
        endcase
    endfunction

    assign rom_data_i = rom_word(rom_addr_o);

    // One clock edge of the fetch unit as described by its priority rules.
    task automatic model_edge();
        if (rst) begin
            m_pc = 32'h0; m_ce = 1'b0; m_pend_v = 1'b0; m_pend = 32'h0;
            m_id_pc = 32'h0; m_id_inst = 32'h0; m_id_valid = 1'b0;
            return;
        end
        if (flush_i) begin
            m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
        end else if (stall_id_i) begin
        end else if (stall_if_i) begin
            m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
        end else begin
            m_id_pc = m_pc; m_id_inst = m_ce ? rom_word(m_pc) : rom_word(m_pc); m_id_valid = m_ce;
        end
        if (!m_ce) begin
        end else if (flush_i) begin
            m_pc = flush_pc_i & ~32'd3; m_pend_v = 0;
        end else if (stall_if_i) begin
            if (branch_flag_i) begin
                m_pend_v = 1; m_pend = branch_target_i & ~32'd3;
            end
        end else if (m_pend_v) begin
            m_pc = m_pend; m_pend_v = 0;
        end else if (branch_flag_i) begin
            m_pc = branch_target_i & ~32'd3;
        end else begin
            m_pc = m_pc + 32'd4;
        end
        m_ce = 1'b1;
    endtask

    task automatic quiet();
        rst = 0; stall_if_i = 0; stall_id_i = 0; flush_i = 0; branch_flag_i = 0;
        flush_pc_i = 0; branch_target_i = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1;
        tick();
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got ce=%b addr=%h idpc=%h inst=%h v=%b want all zero",
                     rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
        end
        tick();
        n_cmp++;
        if ({rom_ce_o, rom_addr_o, id_valid_o} !== {1'b1, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_release: got ce=%b addr=%h v=%b want ce=1 addr=0 v=0",
                     rom_ce_o, rom_addr_o, id_valid_o);
        end
    endtask

    task automatic test_basic_fetch();
        logic [31:0] exp_inst [3];
        exp_inst[0] = 32'h3c02_0404; exp_inst[1] = 32'h3442_0404; exp_inst[2] = 32'h3407_0007;
        do_reset();
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++;
            if ({id_pc_o, id_inst_o, id_valid_o} !== {32'(i * 4), exp_inst[i], 1'b1}) begin
                n_err++;
                $display("FAIL fetch_seq[%0d]: got pc=%h inst=%h v=%b want pc=%h inst=%h v=1",
                         i, id_pc_o, id_inst_o, id_valid_o, 32'(i * 4), exp_inst[i]);
            end
        end
    endtask

    task automatic test_stall_both();
        do_reset();
        tick(); tick(); tick();
        stall_if_i = 1; stall_id_i = 1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({rom_addr_o, id_pc_o, id_inst_o, id_valid_o} !== {32'h8, 32'h4, 32'h3442_0404, 1'b1}) begin
                n_err++;
                $display("FAIL stall_hold[%0d]: got addr=%h idpc=%h inst=%h v=%b want 8/4/34420404/1",
                         i, rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
            end
        end
        quiet();
        tick();
        n_cmp++;
        if ({rom_addr_o, id_pc_o, id_inst_o, id_valid_o} !== {32'hC, 32'h8, 32'h3407_0007, 1'b1}) begin
            n_err++;
            $display("FAIL stall_release: got addr=%h idpc=%h inst=%h v=%b want c/8/34070007/1",
                     rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
        end
    endtask

    task automatic test_branch_delay_slot();
        do_reset();
        for (int i = 0; i < 5; i++) tick();
        n_cmp++;
        if (rom_addr_o !== 32'h10) begin
            n_err++;
            $display("FAIL branch_setup: got addr=%h want 00000010", rom_addr_o);
        end
        branch_flag_i = 1; branch_target_i = 32'h30;
        tick();
        quiet();
        n_cmp++;
        if ({rom_addr_o, id_pc_o, id_inst_o, id_valid_o} !== {32'h30, 32'h10, 32'h3408_0008, 1'b1}) begin
            n_err++;
            $display("FAIL delay_slot: got addr=%h idpc=%h inst=%h v=%b want 30/10/34080008/1",
                     rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
        end
        tick();
        n_cmp++;
        if ({id_pc_o, id_inst_o} !== {32'h30, 32'h0002_14c0}) begin
            n_err++;
            $display("FAIL branch_target_inst: got idpc=%h inst=%h want 30/000214c0",
                     id_pc_o, id_inst_o);
        end
    endtask

    task automatic test_stall_if_branch();
        do_reset();
        tick(); tick(); tick();
        stall_if_i = 1; branch_flag_i = 1; branch_target_i = 32'h28;
        tick();
        quiet();
        n_cmp++;
        if ({rom_addr_o, id_pc_o, id_inst_o, id_valid_o} !== {32'h8, 32'h0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL bubble: got addr=%h idpc=%h inst=%h v=%b want 8/0/0/0",
                     rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
        end
        tick();
        n_cmp++;
        if (rom_addr_o !== 32'h28) begin
            n_err++;
            $display("FAIL pending_redirect: got addr=%h want 00000028", rom_addr_o);
        end
        tick();
        n_cmp++;
        if (rom_addr_o !== 32'h2C) begin
            n_err++;
            $display("FAIL pending_cleared: got addr=%h want 0000002c", rom_addr_o);
        end
    endtask

    task automatic test_flush();
        do_reset();
        tick(); tick(); tick();
        stall_if_i = 1; stall_id_i = 1; flush_i = 1; flush_pc_i = 32'h20;
        branch_flag_i = 1; branch_target_i = 32'h3C;
        tick();
        quiet();
        n_cmp++;
        if ({rom_addr_o, id_inst_o, id_valid_o} !== {32'h20, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL flush: got addr=%h inst=%h v=%b want 20/0/0", rom_addr_o, id_inst_o, id_valid_o);
        end
        tick();
        n_cmp++;
        if ({rom_addr_o, id_pc_o, id_valid_o} !== {32'h24, 32'h20, 1'b1}) begin
            n_err++;
            $display("FAIL flush_no_pending: got addr=%h idpc=%h v=%b want 24/20/1",
                     rom_addr_o, id_pc_o, id_valid_o);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        tick(); tick();
        branch_flag_i = 1; branch_target_i = 32'hFFFF_FFFE;
        tick();
        quiet();
        n_cmp++;
        if (rom_addr_o !== 32'hFFFF_FFFC) begin
            n_err++;
            $display("FAIL align: got addr=%h want fffffffc", rom_addr_o);
        end
        tick();
        n_cmp++;
        if (rom_addr_o !== 32'h0) begin
            n_err++;
            $display("FAIL wrap: got addr=%h want 00000000", rom_addr_o);
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick(); tick(); tick();
        stall_if_i = 1; branch_flag_i = 1; branch_target_i = 32'h40;
        tick();
        stall_if_i = 0; branch_flag_i = 0; rst = 1;
        tick();
        n_cmp++;
        if ({rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o} !== {1'b0, 32'h0, 32'h0, 32'h0, 1'b0}) begin
            n_err++;
            $display("FAIL mid_reset: got ce=%b addr=%h idpc=%h inst=%h v=%b want all zero",
                     rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o);
        end
        rst = 0;
        tick(); tick();
        n_cmp++;
        if ({rom_ce_o, rom_addr_o} !== {1'b1, 32'h4}) begin
            n_err++;
            $display("FAIL mid_reset_restart: got ce=%b addr=%h want 1/00000004", rom_ce_o, rom_addr_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(99) < 2);
            flush_i         = ($urandom_range(99) < 5);
            stall_if_i      = ($urandom_range(99) < 25);
            stall_id_i      = ($urandom_range(99) < 25);
            branch_flag_i   = ($urandom_range(99) < 15);
            flush_pc_i      = $urandom;
            branch_target_i = $urandom;
            tick();
            n_cmp++;
            if ({rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o} !==
                {m_ce, m_pc, m_id_pc, m_id_inst, m_id_valid}) begin
                n_err++;
                $display("FAIL random[%0d]: got ce=%b addr=%h idpc=%h inst=%h v=%b want ce=%b addr=%h idpc=%h inst=%h v=%b",
                         i, rom_ce_o, rom_addr_o, id_pc_o, id_inst_o, id_valid_o,
                         m_ce, m_pc, m_id_pc, m_id_inst, m_id_valid);
            end
        end
        quiet();
    endtask

    initial begin
        quiet();
        m_pc = 0; m_ce = 0; m_pend_v = 0; m_pend = 0; m_id_pc = 0; m_id_inst = 0; m_id_valid = 0;
        test_reset();
        test_basic_fetch();
        test_stall_both();
        test_branch_delay_slot();
        test_stall_if_branch();
        test_flush();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Instruction-fetch front end of the five-stage MIPS pipeline.
- Owns the program counter and drives the instruction ROM address and chip-enable.
- Captures the returned instruction word into the IF/ID pipeline register for the decode stage.
- Handles stall, branch/jump redirect with MIPS delay-slot semantics, and exception flush.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- ADDR_W, 32, PC / ROM address width.
- INST_W, 32, instruction word width.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_if_i  in  1  hold the PC this cycle.
- stall_id_i  in  1  hold the IF/ID register this cycle.
- flush_i  in  1  exception flush; redirect the PC to flush_pc_i.
- flush_pc_i  in  ADDR_W  exception handler address.
- branch_flag_i  in  1  taken branch/jump resolved in ID.
- branch_target_i  in  ADDR_W  redirect target.
- rom_data_i  in  INST_W  instruction word from ROM; combinational in the same cycle.
- rom_addr_o  out  ADDR_W  fetch address (the PC).
- rom_ce_o  out  1  ROM chip enable.
- id_pc_o  out  ADDR_W  PC of the instruction in ID.
- id_inst_o  out  INST_W  instruction in ID.
- id_valid_o  out  1  ID holds a real instruction, not a bubble.

Behaviour:
- Reset (rst=1 at an edge): rom_ce_o=0, rom_addr_o=RESET_PC, id_pc_o=0, id_inst_o=0, id_valid_o=0, pending-redirect register cleared.
- First edge with rst=0: rom_ce_o goes to 1; PC stays RESET_PC. The first fetch address is RESET_PC.
- The PC advances only on edges where rom_ce_o was already 1.
- PC next-state priority (highest first):
  1. rst
  2. rom_ce_o==0 (hold)
  3. flush_i: PC <= flush_pc_i
  4. stall_if_i: hold; if branch_flag_i, latch branch_target_i into the pending register
  5. pending valid: PC <= pending target, clear pending
  6. branch_flag_i: PC <= branch_target_i
  7. otherwise PC <= PC+4
- Delay slot: the instruction fetched in the cycle branch_flag_i is high is never squashed and enters IF/ID normally.
- Redirect alignment: targets have bits [1:0] forced to 0.
- Wrap: PC+4 is modulo 2^32, so 0xFFFF_FFFC advances to 0x0000_0000.
- IF/ID update priority (highest first):
  1. rst or flush_i: clear pc, inst and valid to 0.
  2. stall_id_i: hold all outputs.
  3. stall_if_i with stall_id_i=0: insert a bubble (inst=0, valid=0, pc=0).
  4. otherwise capture id_pc_o<=rom_addr_o, id_inst_o<=rom_data_i, id_valid_o<=rom_ce_o.
- flush_i wins over a simultaneous branch_flag_i or stall and also clears the pending register.
- A reset asserted mid-stall or with a redirect pending discards everything; the next fetch is RESET_PC.
- Latency: instruction at address A appears on id_inst_o one edge after rom_addr_o==A with no stall.

Decomposition:
- Shared DEFINE package: RST_ENABLE, CHIP_ENABLE/CHIP_DISABLE, ZERO_WORD, INST_ADDR_BUS, INST_BUS, STALL/FLUSH level constants.
- Sub-module if_id_reg holds the IF/ID pipeline register with its hold/bubble/flush logic.
- PC, next-PC mux and pending-redirect logic stay in fetch_pc_unit.

Test Plan:
- Reset release with the standard ROM image:
  - Cycle 1: rom_ce_o=1, rom_addr_o=0x0.
  - Next edges: id_inst_o=0x3c020404 (id_pc 0x0), then 0x34420404 (0x4), then 0x34070007 (0x8); valid=1.
- Branch with target 0x30 asserted while rom_addr_o=0x10:
  - id_inst_o=0x34080008 (delay slot, kept).
  - Next rom_addr_o=0x30; then id_inst_o=0x000214c0.
- stall_if_i=stall_id_i=1 for 2 cycles at rom_addr_o=0x8:
  - PC holds 0x8; ID holds 0x4/0x34420404.
  - On release, ID gets 0x8/0x34070007.
- stall_if_i=1, stall_id_i=0 with branch_flag_i, target 0x28, for 1 cycle:
  - ID bubble (valid=0, inst=0); PC held.
  - Next edge PC=0x28; pending clears.
- flush_i with flush_pc_i=0x20 during stall and a simultaneous branch to 0x3C:
  - PC=0x20; ID valid=0, inst=0.
  - Branch ignored; pending empty.
- Redirect target 0xFFFF_FFFE:
  - PC=0xFFFF_FFFC, then 0x0000_0000.
- Mid-run rst=1:
  - All outputs return to reset values; fetch restarts at 0x0.
